// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared PC_src redirect encodings and PC-stage state type
package pc_unit_pkg;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_EXC = 2'b01;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_HLT = 2'b11;
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } pc_state_e;
endpackage

// File: rtl/pc_drain_ctr.sv
// pc_drain_ctr: drain countdown; load DRAIN_CYC-1, decrement, clear; done when zero. Ports: clk, rst, load, clr, dec -> done
module pc_drain_ctr #(
  parameter int DRAIN_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic dec,
  output logic done
);
  localparam int W = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(DRAIN_CYC - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? LOAD_VAL : clr ? '0 : dec ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == '0;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, redirect select (exc > halt > branch > seq), EPC, one-cycle flush, drain-then-halt.
//   in: clk, rst (async high), PC_src[1:0], target, fault_pc, stall
//   out: PC, PC_plus (comb PC+PC_INC), flush, epc, halted
//   optional PC_PERF_CNT_EN: redirect_cnt, cycle_cnt (saturating, frozen when halted)
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int unsigned PC_INC = 1,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] EXC_VECTOR = AW'('h3F0),
  parameter int DRAIN_CYC = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    PC_src,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] fault_pc,
  input  logic          stall,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] PC_plus,
  output logic          flush,
  output logic [AW-1:0] epc,
  output logic          halted
`ifdef PC_PERF_CNT_EN
  ,output logic [31:0]  redirect_cnt,
  output logic [31:0]   cycle_cnt
`endif
);
  pc_state_e state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, epc_q, epc_d;
  logic flush_q, flush_d, halted_q, halted_d;
  logic ld, clr, dec, done, redirect;
  assign PC_plus = pc_q + AW'(PC_INC);
  pc_drain_ctr #(.DRAIN_CYC(DRAIN_CYC)) u_drain (
    .clk(clk), .rst(rst), .load(ld), .clr(clr), .dec(dec), .done(done)
  );
  always_comb begin
    pc_d = pc_q;
    epc_d = epc_q;
    flush_d = 1'b0;
    halted_d = halted_q;
    state_d = state_q;
    ld = 1'b0;
    clr = 1'b0;
    dec = 1'b0;
    redirect = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (PC_src == PCSRC_EXC) begin
          pc_d = EXC_VECTOR;
          epc_d = fault_pc;
          flush_d = 1'b1;
          redirect = 1'b1;
        end else if (PC_src == PCSRC_HLT) begin
          flush_d = 1'b1;
          ld = 1'b1;
          state_d = ST_DRAIN;
          redirect = 1'b1;
        end else if (PC_src == PCSRC_BR) begin
          pc_d = target;
          flush_d = 1'b1;
          redirect = 1'b1;
        end else if (!stall) pc_d = PC_plus;
      end
      ST_DRAIN: begin
        // a late fault from an older instruction still in flight cancels the halt
        if (PC_src == PCSRC_EXC) begin
          pc_d = EXC_VECTOR;
          epc_d = fault_pc;
          flush_d = 1'b1;
          clr = 1'b1;
          state_d = ST_RUN;
          redirect = 1'b1;
        end else if (done) begin
          state_d = ST_HALTED;
          halted_d = 1'b1;
        end else dec = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_RUN;
      pc_q <= RESET_PC;
      epc_q <= '0;
      flush_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      epc_q <= epc_d;
      flush_q <= flush_d;
      halted_q <= halted_d;
    end
  assign PC = pc_q;
  assign epc = epc_q;
  assign flush = flush_q;
  assign halted = halted_q;
`ifdef PC_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, redirect_cnt_d, cycle_cnt_q, cycle_cnt_d;
  always_comb begin
    redirect_cnt_d = redirect && ~&redirect_cnt_q ? redirect_cnt_q + 1'b1 : redirect_cnt_q;
    cycle_cnt_d = state_q != ST_HALTED && ~&cycle_cnt_q ? cycle_cnt_q + 1'b1 : cycle_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      redirect_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  assign redirect_cnt = redirect_cnt_q;
  assign cycle_cnt = cycle_cnt_q;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed + randomized checks of pc_unit against a behavioural model
module tb_pc_unit;
  localparam int DRAIN_CYC = 4;
  localparam logic [31:0] EXC_V = 32'h3F0;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0;
  logic [1:0] PC_src = 2'b00;
  logic [31:0] target = '0, fault_pc = '0;
  logic [31:0] PC, PC_plus, epc;
  logic flush, halted;
  int n_checks = 0, n_fail = 0;
  logic [31:0] m_pc, m_epc;
  logic m_flush, m_halted;
  int m_mode, m_left;
`ifdef PC_PERF_CNT_EN
  logic [31:0] redirect_cnt, cycle_cnt, m_red, m_cyc;
`endif
  pc_unit dut (
    .clk(clk), .rst(rst), .PC_src(PC_src), .target(target), .fault_pc(fault_pc),
    .stall(stall), .PC(PC), .PC_plus(PC_plus), .flush(flush), .epc(epc), .halted(halted)
`ifdef PC_PERF_CNT_EN
    , .redirect_cnt(redirect_cnt), .cycle_cnt(cycle_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pc = '0; m_epc = '0; m_flush = 0; m_halted = 0; m_mode = 0; m_left = 0;
`ifdef PC_PERF_CNT_EN
    m_red = '0; m_cyc = '0;
`endif
  endtask
  task automatic check_all();
    check("PC", PC, m_pc);
    check("PC_plus", PC_plus, m_pc + 32'd1);
    check("epc", epc, m_epc);
    check("flush", {31'b0, flush}, {31'b0, m_flush});
    check("halted", {31'b0, halted}, {31'b0, m_halted});
`ifdef PC_PERF_CNT_EN
    check("redirect_cnt", redirect_cnt, m_red);
    check("cycle_cnt", cycle_cnt, m_cyc);
`endif
  endtask
  // mode: 0 running, 1 draining (m_left edges until halted), 2 halted
  task automatic model_step();
    bit red = 0;
    int prev = m_mode;
    m_flush = 0;
    if (m_mode == 1) begin
      if (PC_src == 2'b01) begin
        m_pc = EXC_V; m_epc = fault_pc; m_flush = 1; m_mode = 0; red = 1;
      end else begin
        m_left--;
        if (m_left == 0) begin m_mode = 2; m_halted = 1; end
      end
    end else if (m_mode == 0) begin
      red = PC_src != 2'b00;
      m_flush = red;
      if (PC_src == 2'b01) begin m_pc = EXC_V; m_epc = fault_pc; end
      else if (PC_src == 2'b11) begin m_mode = 1; m_left = DRAIN_CYC; end
      else if (PC_src == 2'b10) m_pc = target;
      else if (!stall) m_pc = m_pc + 32'd1;
    end
`ifdef PC_PERF_CNT_EN
    if (red && m_red != '1) m_red++;
    if (prev != 2 && m_cyc != '1) m_cyc++;
`else
    if (red && prev > 2) m_left = 0;
`endif
  endtask
  task automatic step(input logic [1:0] src, input logic st, input logic [31:0] tg, input logic [31:0] fp);
    PC_src = src; stall = st; target = tg; fault_pc = fp;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b00, 0, '0, '0);
    step(2'b00, 0, '0, '0);
    step(2'b00, 0, '0, '0);
    step(2'b00, 1, '0, '0);
    step(2'b00, 1, '0, '0);
    step(2'b10, 1, 32'h40, '0);
    step(2'b00, 0, '0, '0);
    step(2'b01, 1, 32'h77, 32'h12);
    step(2'b10, 0, 32'h9, '0);
    step(2'b11, 0, '0, '0);
    for (int i = 0; i < DRAIN_CYC; i++) step(2'b00, 1, '0, '0);
    step(2'b10, 0, 32'h55, '0);
    step(2'b01, 0, '0, 32'h33);
    @(negedge clk);
    do_reset();
    step(2'b11, 0, '0, '0);
    step(2'b01, 0, '0, 32'h20);
    step(2'b00, 0, '0, '0);
    step(2'b10, 0, 32'hFFFF_FFFF, '0);
    step(2'b00, 0, '0, '0);
    step(2'b11, 0, '0, '0);
    step(2'b00, 0, '0, '0);
    #2;
    do_reset();
    step(2'b10, 0, 32'h100, '0);
    step(2'b01, 0, '0, 32'h44);
    step(2'b10, 0, 32'h200, '0);
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 15);
      logic [1:0] s = r < 10 ? 2'b00 : r == 10 ? 2'b01 : r < 14 ? 2'b10 : r == 14 ? 2'b11 : 2'b01;
      if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        do_reset();
      end else step(s, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
